// File: rtl/channel_pkg.sv
// Shared definitions for the channel-B sequencer: status bits, command codes,
// result codes, FSM state encoding and the outbound tag bundle.
package channel_pkg;

  localparam int unsigned StatUc   = 6;
  localparam int unsigned StatCe   = 5;
  localparam int unsigned StatDe   = 4;
  localparam int unsigned StatBusy = 3;

  localparam logic [7:0] CmdTestIo = 8'h00;
  localparam logic [7:0] CmdWrite  = 8'h01;
  localparam logic [7:0] CmdRead   = 8'h02;
  localparam logic [7:0] CmdNop    = 8'h03;

  typedef enum logic [1:0] {
    ResOk           = 2'd0,
    ResNoDevice     = 2'd1,
    ResAddrMismatch = 2'd2,
    ResTimeout      = 2'd3
  } result_e;

  typedef enum logic [3:0] {
    StIdle, StSel, StAddrIn, StCmd, StIstat, StIstatAck,
    StData, StDack, StStop, StFstat, StFstatAck, StFinish
  } state_e;

  typedef struct packed {
    logic hold;
    logic select;
    logic address;
    logic command;
    logic service;
  } tags_t;

  function automatic logic is_wait_state(state_e st);
    return (st != StIdle) && (st != StFinish);
  endfunction

  // True when the operation ends right after initial status.
  function automatic logic ends_at_istat(logic [7:0] cmd, logic [7:0] stat);
    return stat[StatBusy] || (stat[StatCe] && stat[StatDe]) ||
           !((cmd == CmdWrite) || (cmd == CmdRead));
  endfunction

endpackage

// File: rtl/channel_tag_timer.sv
// Cycle counter for tag-wait states; restarts on clear and flags when the
// wait has lasted Timeout cycles (Timeout of zero never expires).
module channel_tag_timer #(
  parameter logic [15:0] Timeout = 16'd1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else if (clear_i) begin
      cnt_q <= 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired_o = (Timeout != 16'd0) && (cnt_q >= Timeout);

endmodule

// File: rtl/channel_sequencer.sv
// Channel-side engine: selection, optional READ/WRITE byte transfer with STOP
// at the byte limit, and final status, one operation per start pulse.
module channel_sequencer
  import channel_pkg::*;
#(
  parameter logic [15:0] Timeout = 16'd1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] address_i,
  input  logic [7:0] command_i,
  input  logic [7:0] byte_count_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o,
  output logic [7:0] status_o,
  output logic [7:0] count_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic [7:0] bus_out_o,
  output logic       operational_out_o,
  output logic       hold_out_o,
  output logic       select_out_o,
  output logic       address_out_o,
  output logic       command_out_o,
  output logic       service_out_o,
  output logic       suppress_out_o,
  input  logic [7:0] bus_in_i,
  input  logic       operational_in_i,
  input  logic       request_in_i,
  input  logic       select_in_i,
  input  logic       address_in_i,
  input  logic       status_in_i,
  input  logic       service_in_i
);

  state_e     state_q, state_d;
  result_e    result_q, result_d;
  tags_t      tags_q, tags_d;
  logic [7:0] addr_q, addr_d, cmd_q, cmd_d, limit_q, limit_d;
  logic [7:0] status_q, status_d, count_q, count_d, rx_data_q, rx_data_d, bus_q, bus_d;
  logic       busy_q, busy_d, done_q, done_d, tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic       op_q, timer_expired, timer_clear;
  logic       unused_request;

  assign unused_request = request_in_i;
  assign timer_clear    = (state_d != state_q) || !is_wait_state(state_q);

  channel_tag_timer #(
    .Timeout(Timeout)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    tags_d     = tags_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    limit_d    = limit_q;
    status_d   = status_q;
    count_d    = count_q;
    rx_data_d  = rx_data_q;
    bus_d      = bus_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;

    if (is_wait_state(state_q) && timer_expired) begin
      tags_d   = '0;
      result_d = ResTimeout;
      state_d  = StFinish;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_d   = address_i;
            cmd_d    = command_i;
            limit_d  = byte_count_i;
            count_d  = 8'd0;
            result_d = ResOk;
            busy_d   = 1'b1;
            bus_d    = address_i;
            tags_d   = '{hold: 1'b1, select: 1'b1, address: 1'b1, command: 1'b0, service: 1'b0};
            state_d  = StSel;
          end
        end
        StSel: begin
          if (operational_in_i) begin
            tags_d.address = 1'b0;
            state_d        = StAddrIn;
          end else if (select_in_i) begin
            tags_d   = '0;
            result_d = ResNoDevice;
            state_d  = StFinish;
          end
        end
        StAddrIn: begin
          if (address_in_i) begin
            if (bus_in_i != addr_q) begin
              tags_d   = '0;
              result_d = ResAddrMismatch;
              state_d  = StFinish;
            end else begin
              bus_d          = cmd_q;
              tags_d.command = 1'b1;
              state_d        = StCmd;
            end
          end
        end
        StCmd: begin
          if (!address_in_i) begin
            tags_d.command = 1'b0;
            state_d        = StIstat;
          end
        end
        StIstat: begin
          if (status_in_i) begin
            status_d       = bus_in_i;
            tags_d.service = 1'b1;
            tags_d.select  = 1'b0;
            tags_d.hold    = 1'b0;
            state_d        = StIstatAck;
          end
        end
        StIstatAck: begin
          if (!status_in_i) begin
            tags_d.service = 1'b0;
            if (ends_at_istat(cmd_q, status_q)) begin
              result_d = ResOk;
              state_d  = StFinish;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          // Status wins over a simultaneous service request.
          if (status_in_i) begin
            status_d       = bus_in_i;
            tags_d.service = 1'b1;
            state_d        = StFstatAck;
          end else if (service_in_i) begin
            if (count_q == limit_q) begin
              tags_d.command = 1'b1;
              state_d        = StStop;
            end else if (cmd_q == CmdRead) begin
              rx_data_d      = bus_in_i;
              rx_valid_d     = 1'b1;
              tags_d.service = 1'b1;
              count_d        = count_q + 8'd1;
              state_d        = StDack;
            end else if (tx_valid_i) begin
              bus_d          = tx_data_i;
              tx_ready_d     = 1'b1;
              tags_d.service = 1'b1;
              count_d        = count_q + 8'd1;
              state_d        = StDack;
            end
          end
        end
        StDack: begin
          if (!service_in_i) begin
            tags_d.service = 1'b0;
            state_d        = StData;
          end
        end
        StStop: begin
          if (!service_in_i) begin
            tags_d.command = 1'b0;
            state_d        = StFstat;
          end
        end
        StFstat: begin
          if (status_in_i) begin
            status_d       = bus_in_i;
            tags_d.service = 1'b1;
            state_d        = StFstatAck;
          end
        end
        StFstatAck: begin
          if (!status_in_i) begin
            tags_d.service = 1'b0;
            result_d       = ResOk;
            state_d        = StFinish;
          end
        end
        StFinish: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tags_d  = '0;
          bus_d   = 8'd0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      result_q   <= ResOk;
      tags_q     <= '0;
      addr_q     <= 8'd0;
      cmd_q      <= 8'd0;
      limit_q    <= 8'd0;
      status_q   <= 8'd0;
      count_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      bus_q      <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      op_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      tags_q     <= tags_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      limit_q    <= limit_d;
      status_q   <= status_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      bus_q      <= bus_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      op_q       <= 1'b1;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign result_o          = result_q;
  assign status_o          = status_q;
  assign count_o           = count_q;
  assign tx_ready_o        = tx_ready_q;
  assign rx_data_o         = rx_data_q;
  assign rx_valid_o        = rx_valid_q;
  assign bus_out_o         = bus_q;
  assign operational_out_o = op_q;
  assign hold_out_o        = tags_q.hold;
  assign select_out_o      = tags_q.select;
  assign address_out_o     = tags_q.address;
  assign command_out_o     = tags_q.command;
  assign service_out_o     = tags_q.service;
  assign suppress_out_o    = 1'b0;

endmodule
